// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and buffer entry type for the fetch unit
package fetch_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC           = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - synchronous fetch FIFO with flush and a registered head
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_push  = push_i && (!full_o || pop_i);
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (!flush_i && do_push) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, fault flag and push/redirect control in front of the fetch buffer
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_fault
);

  logic [31:0]  fpc_q, fpc_d;
  logic         fault_q, fault_d;
  logic         push, pop, flush;
  logic         buf_full, buf_empty;
  fetch_entry_t head;
  fetch_entry_t push_entry;

  assign imem_addr   = fpc_q;
  assign fetch_fault = fault_q;
  assign out_valid   = !buf_empty;
  assign out_instr   = head.instr;
  assign out_pc      = head.pc;
  assign push_entry  = '{pc: fpc_q, instr: imem_rd};

  // A redirect wins over everything: flush, retarget, and never consume the head.
  always_comb begin
    fpc_d   = fpc_q;
    fault_d = fault_q;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      flush   = 1'b1;
      fpc_d   = redirect_pc;
      fault_d = |redirect_pc[1:0];
    end else begin
      pop  = !buf_empty && out_ready;
      push = !fault_q && (!buf_full || pop);
      if (push) fpc_d = fpc_q + PC_INC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q   <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      fpc_q   <= fpc_d;
      fault_q <= fault_d;
    end
  end

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (push_entry),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .head_o  (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a queue-based reference model
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          D   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  logic [63:0] mq[$];
  logic [31:0] m_fpc;
  bit          m_fault;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(D)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fetch_fault    (fetch_fault)
  );

  // Word n encodes addi x(n+1), x0, n
  function automatic logic [31:0] rom(input logic [31:0] a);
    logic [31:0] n;
    n = a >> 2;
    return (n << 20) | ((n + 32'd1) << 7) | 32'h13;
  endfunction

  assign imem_rd = rom(imem_addr);

  task automatic model_reset();
    mq.delete();
    m_fpc   = RPC;
    m_fault = 1'b0;
  endtask

  // Advance one clock; the model consumes the inputs the DUT saw at that edge.
  task automatic step();
    int sz;
    bit p_pop, p_push;
    @(posedge clk);
    sz = mq.size();
    if (redirect_valid) begin
      mq.delete();
      m_fpc   = redirect_pc;
      m_fault = (redirect_pc[1:0] != 2'b00);
    end else begin
      p_pop  = (sz > 0) && out_ready;
      p_push = !m_fault && ((sz < D) || p_pop);
      if (p_pop) void'(mq.pop_front());
      if (p_push) begin
        mq.push_back({m_fpc, rom(m_fpc)});
        m_fpc = m_fpc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (imem_addr !== RPC) begin errors++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RPC); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fetch_fault); end
    checks++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin errors++; $display("FAIL reset_head: got %h/%h expected 0/0", out_pc, out_instr); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    rst_n = 1'b1;
    model_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_latency: got %b expected 0", out_valid); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== rom(32'(4 * i))) begin
        errors++;
        $display("FAIL stream_%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h", i, out_valid, out_pc, out_instr, 32'(4 * i), rom(32'(4 * i)));
      end
    end
  endtask

  task automatic test_stall();
    rst_n = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (5) step();
    checks++; if (imem_addr !== RPC + 32'(4 * D)) begin errors++; $display("FAIL stall_addr: got %h expected %h", imem_addr, RPC + 32'(4 * D)); end
    checks++; if (out_valid !== 1'b1 || out_pc !== RPC) begin errors++; $display("FAIL stall_head: got v=%b pc=%h expected v=1 pc=%h", out_valid, out_pc, RPC); end
    step();
    checks++; if (out_pc !== RPC || imem_addr !== m_fpc) begin errors++; $display("FAIL stall_hold: got pc=%h addr=%h expected pc=%h addr=%h", out_pc, imem_addr, RPC, m_fpc); end
  endtask

  task automatic test_redirect();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redirect_bubble: got %b expected 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin errors++; $display("FAIL redirect_target: got v=%b pc=%h expected v=1 pc=00000040", out_valid, out_pc); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h44) begin errors++; $display("FAIL redirect_next: got v=%b pc=%h expected v=1 pc=00000044", out_valid, out_pc); end
  endtask

  task automatic test_fault();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h42;
    step();
    redirect_valid = 1'b0;
    checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL fault_set: got %b expected 1", fetch_fault); end
    repeat (4) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || fetch_fault !== 1'b1 || imem_addr !== 32'h42) begin
        errors++;
        $display("FAIL fault_hold: got v=%b f=%b addr=%h expected v=0 f=1 addr=00000042", out_valid, fetch_fault, imem_addr);
      end
    end
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    checks++; if (fetch_fault !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL fault_clear: got f=%b v=%b expected f=0 v=0", fetch_fault, out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h80) begin errors++; $display("FAIL fault_resume: got v=%b pc=%h expected v=1 pc=00000080", out_valid, out_pc); end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top: got v=%b pc=%h expected v=1 pc=fffffffc", out_valid, out_pc); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || fetch_fault !== 1'b0) begin errors++; $display("FAIL wrap_zero: got v=%b pc=%h f=%b expected v=1 pc=00000000 f=0", out_valid, out_pc, fetch_fault); end
  endtask

  task automatic test_random();
    logic [63:0] h;
    for (int i = 0; i < 400; i++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = $urandom();
      if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) redirect_pc[31:4] = '1;
      step();
      checks++;
      if (out_valid !== (mq.size() != 0) || imem_addr !== m_fpc || fetch_fault !== m_fault) begin
        errors++;
        $display("FAIL random_state_%0d: got v=%b addr=%h f=%b expected v=%b addr=%h f=%b", i, out_valid, imem_addr, fetch_fault, mq.size() != 0, m_fpc, m_fault);
      end
      if (mq.size() != 0) begin
        h = mq[0];
        checks++;
        if ({out_pc, out_instr} !== h) begin
          errors++;
          $display("FAIL random_head_%0d: got %h/%h expected %h/%h", i, out_pc, out_instr, h[63:32], h[31:0]);
        end
      end
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    repeat (D + 2) step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin errors++; $display("FAIL midreset_full: got v=%b pc=%h expected v=1 pc=00000100", out_valid, out_pc); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || imem_addr !== RPC) begin errors++; $display("FAIL midreset_async: got v=%b addr=%h expected v=0 addr=%h", out_valid, imem_addr, RPC); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    model_reset();
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== RPC) begin errors++; $display("FAIL midreset_restart: got v=%b pc=%h expected v=1 pc=%h", out_valid, out_pc, RPC); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_fault();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
